obstacle_detector_n: RTL

Parametrised N-channel obstacle detector for the car model. It synchronises and debounces raw proximity-sensor levels per channel. It produces a clean level, one-cycle rise/fall pulses and sticky event flags per channel, plus a masked summary (any-active, lowest active channel index) for the drive-control FSM. It replaces the fixed four-direction (front/left/right/back) detector; channel 0..3 map to f/l/r/b when CH=4.

---
 rtl/obstacle_detector_n.sv | 93 +++++++++
 1 files changed

// File: rtl/obstacle_detector_n.sv
// N-channel proximity obstacle detector: per-channel synchroniser, debounce,
// edge pulses and sticky flags, plus a masked lowest-index-first summary.
module obstacle_detector_n #(
    parameter int CH         = 4,
    parameter int DEB_CYCLES = 4,
    parameter int IDXW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH-1:0]   det_in,
    input  logic [CH-1:0]   mask,
    input  logic [CH-1:0]   clr,
    output logic [CH-1:0]   level,
    output logic [CH-1:0]   rise,
    output logic [CH-1:0]   fall,
    output logic [CH-1:0]   sticky,
    output logic            any,
    output logic            first_vld,
    output logic [IDXW-1:0] first_idx
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic          s1_reg;
            logic          s2_reg;
            logic          level_reg;
            logic          rise_reg;
            logic          fall_reg;
            logic          sticky_reg;
            logic [CW-1:0] cnt_reg;
            logic          flip;

            // The level flips on the edge where the disagreement has already
            // persisted for DEB_CYCLES-1 counted cycles.
            assign flip = (s2_reg != level_reg) && (cnt_reg == CNT_MAX);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_reg     <= 1'b0;
                    s2_reg     <= 1'b0;
                    cnt_reg    <= '0;
                    level_reg  <= 1'b0;
                    rise_reg   <= 1'b0;
                    fall_reg   <= 1'b0;
                    sticky_reg <= 1'b0;
                end else begin
                    s1_reg <= det_in[gi];
                    s2_reg <= s1_reg;

                    if (s2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (flip) begin
                        level_reg <= s2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end

                    rise_reg <= flip &  s2_reg & ~mask[gi];
                    fall_reg <= flip & ~s2_reg & ~mask[gi];

                    // Set from the visible rise pulse so a clear issued while
                    // the pulse is showing cannot swallow the event.
                    sticky_reg <= rise_reg | (sticky_reg & ~clr[gi]);
                end
            end

            assign level[gi]  = level_reg;
            assign rise[gi]   = rise_reg;
            assign fall[gi]   = fall_reg;
            assign sticky[gi] = sticky_reg;
        end
    endgenerate

    logic [CH-1:0] active;
    assign active    = level & ~mask;
    assign any       = |active;
    assign first_vld = any;

    always_comb begin
        first_idx = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (active[i]) begin
                first_idx = IDXW'(i);
            end
        end
    end

endmodule
